// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op encodings, access
// direction flags, reset constants, FSM states and the op-to-size helper.
package load_store_unit_pkg;

  localparam logic TRUE      = 1'b1;
  localparam logic FALSE     = 1'b0;
  localparam logic READ_SIT  = 1'b0;
  localparam logic WRITE_SIT = 1'b1;

  localparam logic [5:0] OP_ENUM_LB  = 6'd20;
  localparam logic [5:0] OP_ENUM_LH  = 6'd21;
  localparam logic [5:0] OP_ENUM_LW  = 6'd22;
  localparam logic [5:0] OP_ENUM_LBU = 6'd23;
  localparam logic [5:0] OP_ENUM_LHU = 6'd24;
  localparam logic [5:0] OP_ENUM_SB  = 6'd25;
  localparam logic [5:0] OP_ENUM_SH  = 6'd26;
  localparam logic [5:0] OP_ENUM_SW  = 6'd27;

  typedef logic [31:0] DATA_TYPE;
  typedef logic [31:0] ADDR_TYPE;
  typedef logic [4:0]  ROB_TYPE;

  localparam DATA_TYPE DATA_RESET = 32'd0;
  localparam ROB_TYPE  ROB_RESET  = 5'd0;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_LAST,
    LSU_FINISH
  } lsu_state_e;

  // Number of byte accesses an op needs on the memory-controller port.
  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    case (op)
      OP_ENUM_LB, OP_ENUM_LBU, OP_ENUM_SB: op_bytes = 3'd1;
      OP_ENUM_LH, OP_ENUM_LHU, OP_ENUM_SH: op_bytes = 3'd2;
      default:                             op_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// lsu_load_extender: turns the assembled little-endian load bytes into the
// architectural 32-bit result (sign extension for LB/LH, zero for LBU/LHU).
module lsu_load_extender
  import load_store_unit_pkg::*;
#(
  parameter int OP_WIDTH = 6
) (
  input  logic [OP_WIDTH-1:0] op_i,
  input  logic [31:0]         bytes_i,
  output logic [31:0]         word_o
);

  // Select the extension by op; unused upper bytes are ignored.
  always_comb begin
    word_o = bytes_i;
    case (op_i)
      OP_ENUM_LB:  word_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
      OP_ENUM_LBU: word_o = {24'd0, bytes_i[7:0]};
      OP_ENUM_LH:  word_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
      OP_ENUM_LHU: word_o = {16'd0, bytes_i[15:0]};
      default:     word_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: takes one load/store from the LSB and performs it as a
// sequence of byte accesses on the memory-controller port. Loads are
// assembled little-endian, extended and broadcast on the CDB.
// Optional feature macro: LSU_STATS_EN adds load_count/store_count outputs.
//
// state  | meaning
// IDLE   | waiting for a request
// REQ    | presenting byte k, advancing on grant
// LAST   | load only: capturing the final read byte
// FINISH | end pulse (and CDB pulse for loads); may accept the next request
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ROB_WIDTH = 5,
  parameter int OP_WIDTH  = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 enable_from_lsb,
  input  logic                 read_write_flag_from_lsb,
  input  logic [OP_WIDTH-1:0]  op_enum_from_lsb,
  input  logic [31:0]          address_from_lsb,
  input  logic [31:0]          data_from_lsb,
  input  logic [ROB_WIDTH-1:0] rob_id_from_lsb,
  output logic                 busy_to_lsb,
  output logic                 end_to_lsb,
  output logic                 mem_enable_to_mc,
  output logic                 mem_wr_to_mc,
  output logic [31:0]          mem_addr_to_mc,
  output logic [7:0]           mem_data_to_mc,
  input  logic                 mem_grant_from_mc,
  input  logic [7:0]           mem_data_from_mc,
  input  logic                 roll_back_flag_from_rob,
  output logic                 cdb_enable,
  output logic [ROB_WIDTH-1:0] cdb_rob_id,
  output logic [31:0]          cdb_result
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]          load_count,
  output logic [31:0]          store_count
`endif
);

  lsu_state_e           state_q, state_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic                 is_store_q, is_store_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [ROB_WIDTH-1:0] rob_q, rob_d;
  logic [2:0]           nbytes_q, nbytes_d;
  logic [2:0]           k_q, k_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [1:0]           rd_idx_q, rd_idx_d;
  logic [31:0]          result_q, result_d;
  logic                 can_take;
  logic                 accept;
  logic [31:0]          ext_word;

  lsu_load_extender #(.OP_WIDTH(OP_WIDTH)) u_ext (
    .op_i    (op_q),
    .bytes_i (result_q),
    .word_o  (ext_word)
  );

  // Next-state logic: byte sequencing, read capture, rollback, acceptance.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    is_store_d = is_store_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rob_d      = rob_q;
    nbytes_d   = nbytes_q;
    k_d        = k_q;
    rd_pend_d  = 1'b0;
    rd_idx_d   = rd_idx_q;
    result_d   = result_q;
    accept     = 1'b0;

    // A load accepted alongside a rollback is speculative; drop it.
    can_take = enable_from_lsb &&
               ((read_write_flag_from_lsb == WRITE_SIT) || !roll_back_flag_from_rob);

    if (rd_pend_q) begin
      result_d[{rd_idx_q, 3'b000} +: 8] = mem_data_from_mc;
    end

    case (state_q)
      LSU_IDLE: accept = can_take;
      LSU_REQ: begin
        if (mem_grant_from_mc) begin
          k_d = k_q + 3'd1;
          if (!is_store_q) begin
            rd_pend_d = 1'b1;
            rd_idx_d  = k_q[1:0];
          end
          if (k_q + 3'd1 == nbytes_q) begin
            state_d = is_store_q ? LSU_FINISH : LSU_LAST;
          end
        end
      end
      LSU_LAST: state_d = LSU_FINISH;
      LSU_FINISH: begin
        state_d = LSU_IDLE;
        accept  = can_take;
      end
      default: state_d = LSU_IDLE;
    endcase

    if (roll_back_flag_from_rob && !is_store_q &&
        (state_q == LSU_REQ || state_q == LSU_LAST)) begin
      state_d   = LSU_IDLE;
      rd_pend_d = 1'b0;
    end

    if (accept) begin
      state_d    = LSU_REQ;
      op_d       = op_enum_from_lsb;
      is_store_d = (read_write_flag_from_lsb == WRITE_SIT);
      addr_d     = address_from_lsb;
      data_d     = data_from_lsb;
      rob_d      = rob_id_from_lsb;
      nbytes_d   = op_bytes(op_enum_from_lsb);
      k_d        = 3'd0;
      result_d   = DATA_RESET;
    end
  end

  // State register; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= LSU_IDLE;
      op_q       <= '0;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rob_q      <= '0;
      nbytes_q   <= '0;
      k_q        <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      result_q   <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      op_q       <= op_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rob_q      <= rob_d;
      nbytes_q   <= nbytes_d;
      k_q        <= k_d;
      rd_pend_q  <= rd_pend_d;
      rd_idx_q   <= rd_idx_d;
      result_q   <= result_d;
    end
  end

  // Output decode. FINISH is not counted as busy so the LSB can see the
  // unit free during the end-pulse cycle and a request can be taken there.
  always_comb begin
    busy_to_lsb      = (state_q == LSU_REQ) || (state_q == LSU_LAST) || enable_from_lsb;
    end_to_lsb       = (state_q == LSU_FINISH);
    cdb_enable       = (state_q == LSU_FINISH) && !is_store_q;
    cdb_rob_id       = cdb_enable ? rob_q : '0;
    cdb_result       = cdb_enable ? ext_word : DATA_RESET;
    mem_enable_to_mc = (state_q == LSU_REQ);
    mem_wr_to_mc     = (state_q == LSU_REQ) && is_store_q;
    mem_addr_to_mc   = (state_q == LSU_REQ) ? addr_q + {29'd0, k_q} : 32'd0;
    mem_data_to_mc   = mem_wr_to_mc ? data_q[{k_q[1:0], 3'b000} +: 8] : 8'd0;
  end

`ifdef LSU_STATS_EN
  logic [31:0] load_cnt_q, store_cnt_q;

  // Completion counters, bumped once per end pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else if (rdy_in && state_q == LSU_FINISH) begin
      if (is_store_q) store_cnt_q <= store_cnt_q + 32'd1;
      else            load_cnt_q  <= load_cnt_q + 32'd1;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-addressed memory model plus a
// reference for load assembly/extension and completion timing.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        enable_from_lsb = 1'b0;
  logic        read_write_flag_from_lsb = 1'b0;
  logic [5:0]  op_enum_from_lsb = '0;
  logic [31:0] address_from_lsb = '0;
  logic [31:0] data_from_lsb = '0;
  logic [4:0]  rob_id_from_lsb = '0;
  logic        busy_to_lsb, end_to_lsb;
  logic        mem_enable_to_mc, mem_wr_to_mc;
  logic [31:0] mem_addr_to_mc;
  logic [7:0]  mem_data_to_mc;
  logic        mem_grant_from_mc = 1'b0;
  logic [7:0]  mem_data_from_mc = '0;
  logic        roll_back_flag_from_rob = 1'b0;
  logic        cdb_enable;
  logic [4:0]  cdb_rob_id;
  logic [31:0] cdb_result;
`ifdef LSU_STATS_EN
  logic [31:0] load_count, store_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_loads = 0;
  int exp_stores = 0;
  logic [7:0] mem [logic [31:0]];
  logic [5:0] ops [8];

  always #5 clk_in = ~clk_in;

  load_store_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .enable_from_lsb(enable_from_lsb),
    .read_write_flag_from_lsb(read_write_flag_from_lsb),
    .op_enum_from_lsb(op_enum_from_lsb),
    .address_from_lsb(address_from_lsb),
    .data_from_lsb(data_from_lsb),
    .rob_id_from_lsb(rob_id_from_lsb),
    .busy_to_lsb(busy_to_lsb), .end_to_lsb(end_to_lsb),
    .mem_enable_to_mc(mem_enable_to_mc), .mem_wr_to_mc(mem_wr_to_mc),
    .mem_addr_to_mc(mem_addr_to_mc), .mem_data_to_mc(mem_data_to_mc),
    .mem_grant_from_mc(mem_grant_from_mc), .mem_data_from_mc(mem_data_from_mc),
    .roll_back_flag_from_rob(roll_back_flag_from_rob),
    .cdb_enable(cdb_enable), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result)
`ifdef LSU_STATS_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'(a * 32'd7 + 32'd3) ^ a[15:8];
  endfunction

  function automatic int nbytes(input logic [5:0] op);
    if (op == OP_ENUM_LB || op == OP_ENUM_LBU || op == OP_ENUM_SB) return 1;
    if (op == OP_ENUM_LH || op == OP_ENUM_LHU || op == OP_ENUM_SH) return 2;
    return 4;
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return op == OP_ENUM_SB || op == OP_ENUM_SH || op == OP_ENUM_SW;
  endfunction

  // Little-endian value of the accessed bytes, then signed reinterpretation.
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
    longint v = 0;
    for (int i = 0; i < nbytes(op); i++) v += longint'(rd(a + 32'(i))) << (8 * i);
    if (op == OP_ENUM_LB && v >= 128) v -= 256;
    if (op == OP_ENUM_LH && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  // Issues one request and acts as the memory controller until completion
  // (or, for a rolled-back load, a few quiet cycles). Returns on the negedge
  // of the end-pulse cycle so a follow-up can be issued there.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rob,
                        input int stall_k, input int stall_len, input bit rnd_grant,
                        input int rb_cycle, input int rdy_at, input int rdy_len,
                        input bit issue_now, input string name);
    bit st, rolled, done, rd_pending;
    int n, k, waits, stall_left, exp_end;
    logic [7:0] rd_byte;
    logic [31:0] exp_word;
    st = is_store(op);
    n = nbytes(op);
    exp_word = st ? 32'd0 : ref_load(op, addr);
    rolled = (rb_cycle > 0) && !st;
    if (!issue_now) @(negedge clk_in);
    enable_from_lsb = 1'b1;
    read_write_flag_from_lsb = st ? WRITE_SIT : READ_SIT;
    op_enum_from_lsb = op;
    address_from_lsb = addr;
    data_from_lsb = data;
    rob_id_from_lsb = rob;
    #1;
    checks++;
    if (busy_to_lsb !== 1'b1) begin
      errors++; $display("FAIL %s busy_with_enable got %b want 1", name, busy_to_lsb);
    end
    @(posedge clk_in);
    #1 enable_from_lsb = 1'b0;
    k = 0; waits = 0; stall_left = stall_len; rd_pending = 0; done = 0; rd_byte = '0;
    for (int c = 1; c <= 80 && !done; c++) begin
      bit rdy_now, grant;
      logic [31:0] exp_addr;
      @(negedge clk_in);
      roll_back_flag_from_rob = (c == rb_cycle);
      rdy_now = !(c >= rdy_at && c < rdy_at + rdy_len);
      rdy_in = rdy_now;
      if (rdy_now) begin
        mem_data_from_mc = rd_pending ? rd_byte : 8'($urandom);
        rd_pending = 0;
      end
      grant = 0;
      if (rolled && c > rb_cycle) begin
        checks++;
        if (mem_enable_to_mc !== 1'b0 || end_to_lsb !== 1'b0 || cdb_enable !== 1'b0) begin
          errors++;
          $display("FAIL %s rollback_quiet cyc %0d got men=%b end=%b cdb=%b want 0 0 0",
                   name, c, mem_enable_to_mc, end_to_lsb, cdb_enable);
        end
        if (c == rb_cycle + 1) begin
          checks++;
          if (busy_to_lsb !== 1'b0) begin
            errors++; $display("FAIL %s rollback_idle busy got %b want 0", name, busy_to_lsb);
          end
        end
        if (c >= rb_cycle + 4) done = 1;
      end else begin
        if (end_to_lsb === 1'b1) begin
          exp_end = n + (st ? 1 : 2) + waits;
          done = 1;
          checks++;
          if (c != exp_end || busy_to_lsb !== 1'b0 || cdb_enable !== !st) begin
            errors++;
            $display("FAIL %s end_pulse cyc %0d busy %b cdb %b want cyc %0d busy 0 cdb %b",
                     name, c, busy_to_lsb, cdb_enable, exp_end, !st);
          end
          if (!st) begin
            checks++;
            if (cdb_result !== exp_word || cdb_rob_id !== rob) begin
              errors++;
              $display("FAIL %s cdb_data got %h rob %0d want %h rob %0d",
                       name, cdb_result, cdb_rob_id, exp_word, rob);
            end
            exp_loads++;
          end else begin
            checks++;
            if (k != n) begin
              errors++; $display("FAIL %s store_bytes got %0d want %0d", name, k, n);
            end
            exp_stores++;
          end
        end else begin
          checks++;
          if (busy_to_lsb !== 1'b1 || cdb_enable !== 1'b0) begin
            errors++;
            $display("FAIL %s in_flight cyc %0d busy %b cdb %b want 1 0",
                     name, c, busy_to_lsb, cdb_enable);
          end
        end
        if (mem_enable_to_mc === 1'b1) begin
          exp_addr = addr + 32'(k);
          checks++;
          if (k >= n || mem_addr_to_mc !== exp_addr || mem_wr_to_mc !== st ||
              (st && mem_data_to_mc !== 8'(data >> (8 * k)))) begin
            errors++;
            $display("FAIL %s byte_req k=%0d got a=%h wr=%b d=%h want a=%h wr=%b d=%h",
                     name, k, mem_addr_to_mc, mem_wr_to_mc, mem_data_to_mc,
                     exp_addr, st, 8'(data >> (8 * k)));
          end
          if (!rdy_now) grant = 0;
          else if (k == stall_k && stall_left > 0) begin stall_left--; grant = 0; end
          else if (rnd_grant) grant = ($urandom_range(0, 3) != 0);
          else grant = 1;
          if (grant) begin
            if (st) mem[exp_addr] = 8'(data >> (8 * k));
            else begin rd_pending = 1; rd_byte = rd(exp_addr); end
            k++;
          end
        end
        if (!done && (!rdy_now || (mem_enable_to_mc === 1'b1 && !grant))) waits++;
      end
      mem_grant_from_mc = grant;
      if (!done) @(posedge clk_in);
    end
    roll_back_flag_from_rob = 1'b0;
    rdy_in = 1'b1;
    mem_grant_from_mc = 1'b0;
    if (!done) begin
      errors++; checks++; $display("FAIL %s timeout got no end want end pulse", name);
    end
  endtask

  task automatic check_stats(input string name);
`ifdef LSU_STATS_EN
    repeat (2) @(negedge clk_in);
    checks++;
    if (load_count !== 32'(exp_loads) || store_count !== 32'(exp_stores)) begin
      errors++;
      $display("FAIL %s stats got l=%0d s=%0d want l=%0d s=%0d",
               name, load_count, store_count, exp_loads, exp_stores);
    end
`else
    @(negedge clk_in);
`endif
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (busy_to_lsb !== 1'b0 || end_to_lsb !== 1'b0 || mem_enable_to_mc !== 1'b0 ||
        mem_wr_to_mc !== 1'b0 || cdb_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy%b end%b men%b wr%b cdb%b want all 0",
               busy_to_lsb, end_to_lsb, mem_enable_to_mc, mem_wr_to_mc, cdb_enable);
    end
    checks++;
    if (mem_addr_to_mc !== 32'd0 || mem_data_to_mc !== 8'd0 ||
        cdb_rob_id !== 5'd0 || cdb_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_buses got a=%h d=%h rob=%0d res=%h want 0",
               mem_addr_to_mc, mem_data_to_mc, cdb_rob_id, cdb_result);
    end
`ifdef LSU_STATS_EN
    checks++;
    if (load_count !== 32'd0 || store_count !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %0d %0d want 0 0", load_count, store_count);
    end
`endif
    rst_in = 1'b0;
  endtask

  task automatic test_lw();
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    run_op(OP_ENUM_LW, 32'h100, 32'h0, 5'd9, -1, 0, 0, 0, 0, 0, 0, "lw_basic");
    run_op(OP_ENUM_LW, 32'hFFFF_FFFE, 32'h0, 5'd3, -1, 0, 0, 0, 0, 0, 0, "lw_wrap");
  endtask

  task automatic test_extend();
    mem[32'h300] = 8'h80;
    mem[32'h310] = 8'h00; mem[32'h311] = 8'h80;
    mem[32'h320] = 8'h7F;
    run_op(OP_ENUM_LB,  32'h300, 32'h0, 5'd1, -1, 0, 0, 0, 0, 0, 0, "lb_neg");
    run_op(OP_ENUM_LBU, 32'h300, 32'h0, 5'd2, -1, 0, 0, 0, 0, 0, 0, "lbu");
    run_op(OP_ENUM_LH,  32'h310, 32'h0, 5'd4, -1, 0, 0, 0, 0, 0, 0, "lh_neg");
    run_op(OP_ENUM_LHU, 32'h310, 32'h0, 5'd5, -1, 0, 0, 0, 0, 0, 0, "lhu");
    run_op(OP_ENUM_LB,  32'h320, 32'h0, 5'd6, -1, 0, 0, 0, 0, 0, 0, "lb_pos");
  endtask

  task automatic test_store();
    run_op(OP_ENUM_SH, 32'h200, 32'hAABBCCDD, 5'd7, -1, 0, 0, 0, 0, 0, 0, "sh");
    checks++;
    if (rd(32'h200) !== 8'hDD || rd(32'h201) !== 8'hCC) begin
      errors++;
      $display("FAIL sh_memory got %h %h want dd cc", rd(32'h200), rd(32'h201));
    end
    run_op(OP_ENUM_LHU, 32'h200, 32'h0, 5'd8, -1, 0, 0, 0, 0, 0, 0, "sh_readback");
    run_op(OP_ENUM_SB, 32'h203, 32'h12345699, 5'd10, -1, 0, 0, 0, 0, 0, 0, "sb");
  endtask

  task automatic test_stall();
    run_op(OP_ENUM_LW, 32'h100, 32'h0, 5'd11, 1, 3, 0, 0, 0, 0, 0, "lw_stall");
    run_op(OP_ENUM_LH, 32'h40, 32'h0, 5'd12, -1, 0, 0, 0, 2, 2, 0, "lh_rdy_freeze");
  endtask

  task automatic test_rollback();
    run_op(OP_ENUM_LW, 32'h100, 32'h0, 5'd13, -1, 0, 0, 2, 0, 0, 0, "lw_rollback");
    run_op(OP_ENUM_SW, 32'h400, 32'hDEADBEEF, 5'd14, -1, 0, 0, 2, 0, 0, 0, "sw_rollback");
    run_op(OP_ENUM_LW, 32'h400, 32'h0, 5'd15, -1, 0, 0, 0, 0, 0, 0, "sw_readback");
  endtask

  task automatic test_back_to_back();
    run_op(OP_ENUM_LW, 32'h500, 32'h0, 5'd16, -1, 0, 0, 0, 0, 0, 0, "b2b_first");
    run_op(OP_ENUM_SH, 32'h600, 32'h00C0FFEE, 5'd17, -1, 0, 0, 0, 0, 0, 1, "b2b_second");
    run_op(OP_ENUM_LBU, 32'h601, 32'h0, 5'd18, -1, 0, 0, 0, 0, 0, 1, "b2b_third");
    check_stats("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      logic [31:0] a;
      int rb, ra, rl;
      op = ops[$urandom_range(0, 7)];
      a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                      : 32'($urandom_range(0, 255));
      rb = 0; ra = 0; rl = 0;
      if (!is_store(op) && $urandom_range(0, 5) == 0) rb = $urandom_range(1, nbytes(op));
      else if (nbytes(op) >= 2 && $urandom_range(0, 4) == 0) begin ra = 2; rl = $urandom_range(1, 3); end
      run_op(op, a, $urandom, 5'($urandom), -1, 0, 1, rb, ra, rl, bit'($urandom_range(0, 1)), "random");
    end
    check_stats("random");
  endtask

  initial begin
    ops = '{OP_ENUM_LB, OP_ENUM_LH, OP_ENUM_LW, OP_ENUM_LBU,
            OP_ENUM_LHU, OP_ENUM_SB, OP_ENUM_SH, OP_ENUM_SW};
    test_reset();
    test_lw();
    test_extend();
    test_store();
    test_stall();
    test_rollback();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
